buf_stream_reader: RTL

Read-side controller for one `bram_buffer` instance: on `start` it walks `len` consecutive words from `base_addr` and presents them as a valid/ready stream to the compute array. It absorbs the BRAM's one-cycle read latency with a two-entry output FIFO, so downstream backpressure never loses or duplicates a word. The block owns the buffer's address port during a transfer; the write-side mux lives elsewhere.

---
 rtl/osiris_buf_pkg.sv | 20 ++
 rtl/buf_stream_reader_skid_fifo2.sv | 59 +++++
 rtl/buf_stream_reader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/osiris_buf_pkg.sv
// osiris_buf_pkg: shared definitions for the buffer stream reader.
//   buf_rd_state_t    - reader FSM states (IDLE, RUN, DONE)
//   BUF_RD_FIFO_DEPTH - entries in the output skid FIFO
//   buf_addr_next     - buffer address increment with wrap at depth-1
package osiris_buf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } buf_rd_state_t;

  localparam int unsigned BUF_RD_FIFO_DEPTH = 2;

  function automatic int unsigned buf_addr_next(input int unsigned addr,
                                                input int unsigned depth);
    return (addr >= depth - 1) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/buf_stream_reader_skid_fifo2.sv
// skid_fifo2: two-entry registered FIFO whose head slot drives the stream
// directly, so the head word is stable until it is popped.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push, din   - write strobe and data (never asserted when full)
//   pop         - read strobe (only asserted while valid)
//   head        - oldest entry (registered)
//   valid       - FIFO not empty
//   count       - number of stored entries, 0..2
module skid_fifo2
  import osiris_buf_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] slot1;

  assign valid = (count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      slot1 <= '0;
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head  <= din;
          else               slot1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: the new word lands behind whatever remains.
          if (count == 2'd1) begin
            head <= din;
          end else begin
            head  <= slot1;
            slot1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/buf_stream_reader.sv
// buf_stream_reader: walks len consecutive buffer words from base_addr and
// presents them as a valid/ready stream, hiding the one-cycle BRAM latency
// behind a two-entry skid FIFO.
// Optional feature macro: BUF_RD_LAST_EN adds m_last, flagged with the final
// word of each non-empty transfer.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   start              - transfer request, sampled only in IDLE
//   base_addr, len     - first address and word count, sampled with start
//   busy, done         - RUN indicator, one-cycle completion pulse
//   bram_addr          - buffer address port
//   bram_dout          - buffer read data, one cycle after its address
//   m_data, m_valid    - output stream payload and valid
//   m_ready            - output stream ready
//   m_last             - final-word marker (BUF_RD_LAST_EN only)
module buf_stream_reader
  import osiris_buf_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      len,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    bram_addr,
  input  logic [WIDTH-1:0] bram_dout,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
`ifdef BUF_RD_LAST_EN
  ,
  output logic             m_last
`endif
);

`ifdef BUF_RD_LAST_EN
  localparam int unsigned LW = 1;
`else
  localparam int unsigned LW = 0;
`endif
  localparam int unsigned FW = WIDTH + LW;

  buf_rd_state_t state;
  logic [AW:0]   len_q;
  logic [AW:0]   issued;
  logic [AW:0]   accepted;
  logic          inflight;
  logic [1:0]    fifo_count;
  logic [2:0]    occupancy;
  logic          rd_issue;
  logic          pop;
  logic          last_accept;
  logic [FW-1:0] push_data;
  logic [FW-1:0] fifo_head;

  assign pop = m_valid & m_ready;

  // Credit check counts the word still in flight from the BRAM, so a push
  // can never meet a full FIFO.
  always_comb begin
    occupancy   = {1'b0, fifo_count} + {2'b00, inflight};
    rd_issue    = (state == RUN) && (issued < len_q) &&
                  (occupancy < 3'(BUF_RD_FIFO_DEPTH) + {2'b00, pop});
    last_accept = pop && (accepted + (AW+1)'(1) == len_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      issued    <= '0;
      accepted  <= '0;
      bram_addr <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= rd_issue;
      unique case (state)
        IDLE: begin
          if (start) begin
            len_q     <= len;
            bram_addr <= base_addr;
            issued    <= '0;
            accepted  <= '0;
            state     <= (len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (rd_issue) begin
            issued    <= issued + (AW+1)'(1);
            bram_addr <= AW'(buf_addr_next(32'(bram_addr), DEPTH));
          end
          if (pop) accepted <= accepted + (AW+1)'(1);
          if (last_accept) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

`ifdef BUF_RD_LAST_EN
  logic inflight_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight_last <= 1'b0;
    else        inflight_last <= rd_issue && (issued + (AW+1)'(1) == len_q);
  end

  assign push_data = {inflight_last, bram_dout};
  assign m_last    = fifo_head[WIDTH];
`else
  assign push_data = bram_dout;
`endif

  skid_fifo2 #(.W(FW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .din   (push_data),
    .pop   (pop),
    .head  (fifo_head),
    .valid (m_valid),
    .count (fifo_count)
  );

  assign m_data = fifo_head[WIDTH-1:0];

endmodule
